sto_stack: RTL and testbench

- LIFO read-back store for the backpropagation datapath.
- Forward pass pushes one signed activation per cycle; backward pass pops them in reverse order, each value presented for one cycle with a valid strobe.
- Sits between a layer's forward output and its gradient/weight-update logic.
- This is the reader side of the forward-pass value capture.

---
 rtl/sto_stack_pkg.sv | 16 +
 rtl/sto_stack_mem.sv | 34 +++
 rtl/sto_stack.sv | 156 +++++++++++++++
 tb/tb_sto_stack.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/sto_stack_pkg.sv
// Shared definitions for the backpropagation LIFO read-back store.
//   - Default word width and depth.
//   - sto_aw(): address width derivation (ceil(log2(depth))).
//   - sto_word_t: signed data word, also used by the forward-path registers.
package sto_stack_pkg;

  localparam int unsigned StoWidth = 32;
  localparam int unsigned StoDepth = 8;

  typedef logic signed [StoWidth-1:0] sto_word_t;

  function automatic int unsigned sto_aw(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sto_stack_mem.sv
// DEPTH x WIDTH register file backing the stack. No reset; contents are
// only meaningful below the stack's count.
// Ports:
//   clk    rising-edge clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  combinational read data (returns the pre-write value on a
//          same-cycle read/write to one address)
module sto_stack_mem #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sto_stack.sv
// LIFO read-back store: the forward pass pushes one signed word per cycle,
// the backward pass pops them in reverse order with a one-cycle valid pulse.
// Optional feature macro: STO_STACK_ERR_EN builds sticky ovf/unf flags;
// without it both flags are tied to 0.
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-low reset (highest priority)
//   clr    synchronous flush: count to 0, flags cleared, o held
//   push   write i on top of stack
//   pop    read top of stack (o/valid one clock later)
//   i      signed data to push
//   o      registered popped data
//   valid  one-cycle pulse per accepted pop
//   count  stored words, 0..DEPTH
//   full   count == DEPTH
//   empty  count == 0
//   ovf    sticky overflow (push while full)
//   unf    sticky underflow (pop while empty)
module sto_stack
  import sto_stack_pkg::*;
#(
  parameter int unsigned WIDTH = StoWidth,
  parameter int unsigned DEPTH = StoDepth,
  parameter int unsigned AW    = sto_aw(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    push,
  input  logic                    pop,
  input  logic signed [WIDTH-1:0] i,
  output logic signed [WIDTH-1:0] o,
  output logic                    valid,
  output logic [AW:0]             count,
  output logic                    full,
  output logic                    empty,
  output logic                    ovf,
  output logic                    unf
);

  localparam logic [AW:0] CountFull = (AW+1)'(DEPTH);

  logic [AW:0]             count_q, count_d;
  logic signed [WIDTH-1:0] o_q, o_d;
  logic                    valid_q, valid_d;
  logic                    ovf_set, unf_set;

  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] rdata;

  // When full, count[AW-1:0] wraps to 0, so top_idx lands on DEPTH-1.
  assign top_idx = count_q[AW-1:0] - 1'b1;
  assign full    = (count_q == CountFull);
  assign empty   = (count_q == '0);

  sto_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (i),
    .raddr (top_idx),
    .rdata (rdata)
  );

  always_comb begin
    count_d = count_q;
    o_d     = o_q;
    valid_d = 1'b0;
    we      = 1'b0;
    waddr   = count_q[AW-1:0];
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (rst) begin
      if (clr) begin
        count_d = '0;
      end else begin
        case ({push, pop})
          2'b10: begin
            if (!full) begin
              we      = 1'b1;
              count_d = count_q + 1'b1;
            end else begin
              ovf_set = 1'b1;
            end
          end
          2'b01: begin
            if (!empty) begin
              o_d     = rdata;
              valid_d = 1'b1;
              count_d = count_q - 1'b1;
            end else begin
              unf_set = 1'b1;
            end
          end
          2'b11: begin
            valid_d = 1'b1;
            if (!empty) begin
              // Replace top: rdata still shows the old top this cycle.
              o_d   = rdata;
              we    = 1'b1;
              waddr = top_idx;
            end else begin
              o_d = i;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      o_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      o_q     <= o_d;
      valid_q <= valid_d;
    end
  end

`ifdef STO_STACK_ERR_EN
  logic ovf_q, unf_q;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_set) ovf_q <= 1'b1;
      if (unf_set) unf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
  assign unf = unf_q;
`else
  logic unused_flags;
  assign unused_flags = ovf_set ^ unf_set;
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

  assign o     = o_q;
  assign valid = valid_q;
  assign count = count_q;

endmodule

// File: tb/tb_sto_stack.sv
module tb_sto_stack;
  import sto_stack_pkg::*;

  localparam int unsigned Depth = 8;

  logic            clk = 1'b0;
  logic            rst, clr, push, pop;
  logic signed [31:0] i;
  logic signed [31:0] o;
  logic            valid, full, empty, ovf, unf;
  logic [3:0]      count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  sto_word_t   m_mem [Depth];
  int          m_count;
  sto_word_t   m_o;
  bit          m_ovf, m_unf, m_valid;
  sto_word_t   exp_q [$];

  always #5 clk = ~clk;

  sto_stack u_dut (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .i     (i),
    .o     (o),
    .valid (valid),
    .count (count),
    .full  (full),
    .empty (empty),
    .ovf   (ovf),
    .unf   (unf)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit c, input bit pu, input bit po,
                      input sto_word_t d);
    bit exp_ovf, exp_unf;
    rst = r; clr = c; push = pu; pop = po; i = d;
    m_valid = 1'b0;
    if (!r) begin
      m_count = 0; m_o = '0; m_ovf = 0; m_unf = 0;
    end else if (c) begin
      m_count = 0; m_ovf = 0; m_unf = 0;
    end else if (pu && po) begin
      m_valid = 1'b1;
      if (m_count > 0) begin
        m_o = m_mem[m_count-1];
        m_mem[m_count-1] = d;
      end else begin
        m_o = d;
      end
    end else if (pu) begin
      if (m_count < Depth) begin
        m_mem[m_count] = d;
        m_count++;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (po) begin
      if (m_count > 0) begin
        m_count--;
        m_o = m_mem[m_count];
        m_valid = 1'b1;
      end else begin
        m_unf = 1'b1;
      end
    end
    if (m_valid) exp_q.push_back(m_o);

    @(posedge clk);
    #1;
    check("valid", valid, m_valid);
    if (valid) begin
      if (exp_q.size() > 0) check("o_pop", o, exp_q.pop_front());
      else check("sb_spurious_valid", valid, 0);
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      check("o_hold", o, m_o);
    end
    check("count", count, m_count);
    check("full", full, m_count == Depth);
    check("empty", empty, m_count == 0);
`ifdef STO_STACK_ERR_EN
    exp_ovf = m_ovf;
    exp_unf = m_unf;
`else
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
`endif
    check("ovf", ovf, exp_ovf);
    check("unf", unf, exp_unf);
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; i = '0;
    m_count = 0; m_o = '0; m_ovf = 0; m_unf = 0; m_valid = 0;

    // Reset, then push 5, -3, 7 and pop them back in reverse.
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 5);
    step(1, 0, 1, 0, -3);
    step(1, 0, 1, 0, 7);
    step(1, 0, 0, 1, 0);
    check("first_pop_is_7", o, 7);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    check("last_pop_is_5", o, 5);
    step(1, 0, 0, 0, 0);

    // Fill to full, overflow, pop the top, drain.
    for (int k = 1; k <= 8; k++) step(1, 0, 1, 0, k);
    step(1, 0, 1, 0, 99);
    step(1, 0, 0, 1, 0);
    check("pop_after_ovf_is_8", o, 8);
    for (int k = 0; k < 7; k++) step(1, 0, 0, 1, 0);

    // Underflow from empty, then flush clears flags.
    step(1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0);

    // Replace-top then drain.
    step(1, 0, 1, 0, 10);
    step(1, 0, 1, 0, 20);
    step(1, 0, 1, 1, 30);
    check("replace_returns_20", o, 20);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);

    // Pass-through on empty.
    step(1, 0, 1, 1, -42);
    check("passthrough", o, -42);

    // Mid-stream reset with push asserted, then underflow.
    step(1, 0, 1, 0, 11);
    step(1, 0, 1, 0, 12);
    step(1, 0, 1, 0, 13);
    step(0, 0, 1, 0, 14);
    step(1, 0, 0, 1, 0);

    // Clear overrides push/pop in the same cycle.
    step(1, 0, 1, 0, 21);
    step(1, 1, 1, 1, 22);

    // Random traffic.
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 49) == 0),
           $urandom_range(0, 1), $urandom_range(0, 1), sto_word_t'($urandom()));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
